// File: rtl/approx_chk_pkg.sv
// Shared types and width helpers for the approximate-circuit error monitor.
// Holds the sweep FSM state enum and count/sum width functions.
package approx_chk_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Violation counter must hold 2^in_w, hence one extra bit.
    function automatic int cnt_w(input int in_w);
        return in_w + 1;
    endfunction

    // Sum of 2^in_w errors, each below 2^out_w.
    function automatic int sum_w(input int in_w, input int out_w);
        return in_w + out_w;
    endfunction

endpackage

// File: rtl/abs_diff_unit.sv
// Combinational unsigned absolute difference |a - b|.
// Ports: a, b (W bits, unsigned) -> d (W bits).
module abs_diff_unit #(
    parameter int W = 2
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] d
);

    assign d = (a >= b) ? (a - b) : (b - a);

endmodule

// File: rtl/approx_error_monitor.sv
// Exhaustive error monitor comparing an approximate circuit to its exact reference.
// Ports: clk, rst, start, et_i -> vec_o; exact_i, approx_i -> busy, done, pass, stats, fail_vec.
module approx_error_monitor
    import approx_chk_pkg::*;
#(
    parameter int IN_W  = 4,
    parameter int OUT_W = 2,
    parameter int ET_W  = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ET_W-1:0]       et_i,
    output logic [IN_W-1:0]       vec_o,
    input  logic [OUT_W-1:0]      exact_i,
    input  logic [OUT_W-1:0]      approx_i,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [OUT_W-1:0]      max_err,
    output logic [IN_W:0]         err_cnt,
    output logic [IN_W+OUT_W-1:0] err_sum,
    output logic [IN_W-1:0]       fail_vec
);

    localparam int CNT_W = cnt_w(IN_W);
    localparam int SUM_W = sum_w(IN_W, OUT_W);

    state_t state_q;
    state_t state_d;

    logic [IN_W-1:0]  cnt_q;
    logic [ET_W-1:0]  et_q;
    logic [OUT_W-1:0] diff;
    logic [OUT_W-1:0] d_q;
    logic [IN_W-1:0]  vec_q;
    logic             v_q;
    logic             fail_seen_q;
    logic             accept;
    logic             last;
    logic             viol;

    abs_diff_unit #(.W(OUT_W)) u_abs (
        .a (exact_i),
        .b (approx_i),
        .d (diff)
    );

    assign accept = start && (state_q == IDLE || state_q == DONE);
    assign last   = (cnt_q == {IN_W{1'b1}});
    assign viol   = ET_W'(d_q) > et_q;

    assign vec_o = cnt_q;
    assign busy  = (state_q == SWEEP) || (state_q == DRAIN);
    assign done  = (state_q == DONE);
    assign pass  = done && (err_cnt == '0);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = SWEEP;
            SWEEP:   if (last) state_d = DRAIN;
            // Stay until the final captured vector has been accumulated.
            DRAIN:   if (!v_q) state_d = DONE;
            DONE:    if (start) state_d = SWEEP;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            et_q  <= '0;
        end else if (accept) begin
            cnt_q <= '0;
            et_q  <= et_i;
        end else if (state_q == SWEEP) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d_q   <= '0;
            vec_q <= '0;
            v_q   <= 1'b0;
        end else begin
            d_q   <= diff;
            vec_q <= cnt_q;
            v_q   <= (state_q == SWEEP);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            max_err     <= '0;
            err_cnt     <= '0;
            err_sum     <= '0;
            fail_vec    <= '0;
            fail_seen_q <= 1'b0;
        end else if (accept) begin
            max_err     <= '0;
            err_cnt     <= '0;
            err_sum     <= '0;
            fail_vec    <= '0;
            fail_seen_q <= 1'b0;
        end else if (v_q) begin
            if (d_q > max_err) max_err <= d_q;
            err_sum <= err_sum + SUM_W'(d_q);
            if (viol) begin
                err_cnt <= err_cnt + CNT_W'(1);
                if (!fail_seen_q) begin
                    fail_vec    <= vec_q;
                    fail_seen_q <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_approx_error_monitor.sv
// Self-checking bench for approx_error_monitor.
// Drives LUT-defined exact/approx circuits and checks against a sweep model.
module tb_approx_error_monitor;

    localparam int IN_W  = 4;
    localparam int OUT_W = 2;
    localparam int ET_W  = 3;
    localparam int NV    = 1 << IN_W;

    logic                  clk;
    logic                  rst;
    logic                  start;
    logic [ET_W-1:0]       et_i;
    logic [IN_W-1:0]       vec_o;
    logic [OUT_W-1:0]      exact_i;
    logic [OUT_W-1:0]      approx_i;
    logic                  busy;
    logic                  done;
    logic                  pass;
    logic [OUT_W-1:0]      max_err;
    logic [IN_W:0]         err_cnt;
    logic [IN_W+OUT_W-1:0] err_sum;
    logic [IN_W-1:0]       fail_vec;

    logic [OUT_W-1:0] ex_lut [NV];
    logic [OUT_W-1:0] ap_lut [NV];

    int checks = 0;
    int errors = 0;

    approx_error_monitor #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W),
        .ET_W  (ET_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .et_i     (et_i),
        .vec_o    (vec_o),
        .exact_i  (exact_i),
        .approx_i (approx_i),
        .busy     (busy),
        .done     (done),
        .pass     (pass),
        .max_err  (max_err),
        .err_cnt  (err_cnt),
        .err_sum  (err_sum),
        .fail_vec (fail_vec)
    );

    assign exact_i  = ex_lut[vec_o];
    assign approx_i = ap_lut[vec_o];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Whole-sweep reference: statistics over every vector at once.
    task automatic model(input int et, output int m_max, output int m_cnt,
                         output int m_sum, output int m_fail);
        bit found;
        m_max = 0; m_cnt = 0; m_sum = 0; m_fail = 0; found = 0;
        for (int v = 0; v < NV; v++) begin
            int e;
            int a;
            int d;
            e = int'(ex_lut[v]);
            a = int'(ap_lut[v]);
            d = (e > a) ? e - a : a - e;
            if (d > m_max) m_max = d;
            m_sum += d;
            if (d > et) begin
                m_cnt++;
                if (!found) begin
                    found = 1;
                    m_fail = v;
                end
            end
        end
    endtask

    task automatic load_ref_circuits();
        for (int v = 0; v < NV; v++) begin
            int a;
            int b;
            a = v & 3;
            b = (v >> 2) & 3;
            ex_lut[v] = OUT_W'((a > b) ? a - b : b - a);
            ap_lut[v] = OUT_W'(3);
        end
    endtask

    // Runs one sweep, checking handshake/vector every cycle, then the stats.
    task automatic run_sweep(input int et, input int inj);
        int m_max, m_cnt, m_sum, m_fail;
        @(negedge clk);
        start = 1'b1;
        et_i  = ET_W'(et);
        for (int e = 0; e <= NV + 2; e++) begin
            @(posedge clk);
            #1;
            chk("busy", int'(busy), (e < NV + 2) ? 1 : 0);
            chk("done", int'(done), (e == NV + 2) ? 1 : 0);
            chk("vec_o", int'(vec_o), (e < NV) ? e : 0);
            @(negedge clk);
            start = (e + 1 == inj);
            et_i  = ET_W'($urandom);
        end
        start = 1'b0;
        model(et, m_max, m_cnt, m_sum, m_fail);
        chk("pass", int'(pass), (m_cnt == 0) ? 1 : 0);
        chk("max_err", int'(max_err), m_max);
        chk("err_cnt", int'(err_cnt), m_cnt);
        chk("err_sum", int'(err_sum), m_sum);
        chk("fail_vec", int'(fail_vec), m_fail);
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        et_i  = '0;
        load_ref_circuits();
        #12;
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_vec", int'(vec_o), 0);
        chk("rst_sum", int'(err_sum), 0);
        @(negedge clk);
        rst = 1'b0;

        run_sweep(4, -1);
        chk("lit4_pass", int'(pass), 1);
        chk("lit4_max", int'(max_err), 3);
        chk("lit4_sum", int'(err_sum), 28);
        chk("lit4_cnt", int'(err_cnt), 0);

        run_sweep(2, -1);
        chk("lit2_pass", int'(pass), 0);
        chk("lit2_cnt", int'(err_cnt), 4);
        chk("lit2_fail", int'(fail_vec), 0);

        run_sweep(1, -1);
        chk("lit1_cnt", int'(err_cnt), 10);

        run_sweep(3, -1);
        chk("lit3_cnt", int'(err_cnt), 0);
        chk("lit3_pass", int'(pass), 1);

        for (int v = 0; v < NV; v++) ap_lut[v] = ex_lut[v];
        run_sweep(0, -1);
        chk("exact_sum", int'(err_sum), 0);
        chk("exact_max", int'(max_err), 0);

        // Ignored start mid-sweep with a different threshold.
        load_ref_circuits();
        run_sweep(2, 5);
        chk("inj_cnt", int'(err_cnt), 4);

        // Reset in the middle of a sweep.
        @(negedge clk);
        start = 1'b1;
        et_i  = ET_W'(0);
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_busy", int'(busy), 0);
        chk("mid_done", int'(done), 0);
        chk("mid_pass", int'(pass), 0);
        chk("mid_vec", int'(vec_o), 0);
        chk("mid_max", int'(max_err), 0);
        chk("mid_cnt", int'(err_cnt), 0);
        chk("mid_sum", int'(err_sum), 0);
        chk("mid_fail", int'(fail_vec), 0);
        @(negedge clk);
        rst = 1'b0;
        run_sweep(2, -1);
        chk("post_rst_cnt", int'(err_cnt), 4);

        // Random circuits, thresholds and stray starts.
        for (int r = 0; r < 8; r++) begin
            for (int v = 0; v < NV; v++) begin
                ex_lut[v] = OUT_W'($urandom);
                ap_lut[v] = OUT_W'($urandom);
            end
            run_sweep(int'($urandom_range(0, 5)),
                      (r % 2 == 0) ? int'($urandom_range(1, NV + 1)) : -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
